// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 bus-cycle / fetch unit.
package sm83_pkg;

  // Requested M-cycle type, presented by the sequencer.
  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_FETCH = 2'd1,
    BUS_READ  = 2'd2,
    BUS_WRITE = 2'd3
  } bus_op_t;

  // T-state within one M-cycle.
  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } t_state_t;

  localparam logic [7:0] NOP_OPCODE = 8'h00;
  localparam logic [7:0] CB_PREFIX  = 8'hCB;

endpackage

// File: rtl/sm83_tcycle.sv
// Free-running T-state counter: T1 -> T2 -> T3 -> T4 -> T1, held in T1 during reset.
module sm83_tcycle
  import sm83_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  output t_state_t o_t_state,
  output logic     o_t1,
  output logic     o_t3,
  output logic     o_t4
);

  t_state_t r_state;
  t_state_t w_next;

  // State register; async clear returns the counter to T1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= T1;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state sequencing and one-hot strobes.
  always_comb begin
    w_next    = r_state;
    o_t_state = r_state;
    o_t1      = 1'b0;
    o_t3      = 1'b0;
    o_t4      = 1'b0;
    unique case (r_state)
      T1: begin
        w_next = T2;
        o_t1   = 1'b1;
      end
      T2: w_next = T3;
      T3: begin
        w_next = T4;
        o_t3   = 1'b1;
      end
      T4: begin
        w_next = T1;
        o_t4   = 1'b1;
      end
      default: w_next = T1;
    endcase
  end

endmodule

// File: rtl/sm83_fetch.sv
// SM83 bus-cycle and instruction-fetch unit: T-state sequencing, memory bus, PC and IR.
// Optional feature macro: SM83_CB_PREFIX_EN (CB-prefix opcode pairing into one ir_valid).
// The M-cycle request is captured on the clock edge that ends T4, so it is stable for the
// whole following T1..T4. The first M-cycle after reset release is therefore always idle.
module sm83_fetch
  import sm83_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_bus_op,
  input  logic [15:0] i_bus_addr,
  input  logic [7:0]  i_bus_wdata,
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_load_val,
  output logic [15:0] o_pc,
  output logic [7:0]  o_ir,
  output logic        o_ir_cb,
  output logic [7:0]  o_rdata,
  output logic        o_mcycle_done,
  output logic        o_ir_valid,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_din,
  output logic [7:0]  o_mem_dout
);

  t_state_t    w_t_state;
  logic        w_t1;
  logic        w_t3;
  logic        w_t4;

  bus_op_t     r_op;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [15:0] r_pc;
  logic [7:0]  r_ir;
  logic [7:0]  r_rdata;

  bus_op_t     w_op_next;
  logic        w_pc_load_en;
  logic        w_opcode_done;

  sm83_tcycle u_tcycle (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .o_t_state (w_t_state),
    .o_t1      (w_t1),
    .o_t3      (w_t3),
    .o_t4      (w_t4)
  );

`ifdef SM83_CB_PREFIX_EN
  logic r_cb_pending;
  logic r_prefix;
  logic r_ir_cb;

  // CB-prefix tracking: a CB byte arms the pending flag, which forces the next fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cb_pending <= 1'b0;
      r_prefix     <= 1'b0;
      r_ir_cb      <= 1'b0;
    end else begin
      if (w_t3 && (r_op == BUS_FETCH)) begin
        r_cb_pending <= !r_cb_pending && (i_mem_din == CB_PREFIX);
        r_ir_cb      <= r_cb_pending;
      end
      if (w_t4) begin
        r_prefix <= r_cb_pending;
      end
    end
  end

  assign w_op_next     = r_cb_pending ? BUS_FETCH : bus_op_t'(i_bus_op);
  assign w_pc_load_en  = i_pc_load && !r_prefix;
  assign w_opcode_done = !r_cb_pending;
  assign o_ir_cb       = r_ir_cb;
`else
  assign w_op_next     = bus_op_t'(i_bus_op);
  assign w_pc_load_en  = i_pc_load;
  assign w_opcode_done = 1'b1;
  assign o_ir_cb       = 1'b0;
`endif

  // M-cycle request latch, loaded on the edge that ends T4.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= BUS_IDLE;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
    end else if (w_t4) begin
      r_op    <= w_op_next;
      r_addr  <= i_bus_addr;
      r_wdata <= i_bus_wdata;
    end
  end

  // PC, IR and read data: capture at end of T3, PC load at end of T4 overrides increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= RESET_PC;
      r_ir    <= NOP_OPCODE;
      r_rdata <= 8'h00;
    end else begin
      if (w_t3) begin
        if (r_op == BUS_FETCH) begin
          r_ir <= i_mem_din;
          r_pc <= r_pc + 16'd1;
        end else if (r_op == BUS_READ) begin
          r_rdata <= i_mem_din;
        end
      end
      if (w_t4 && w_pc_load_en) begin
        r_pc <= i_pc_load_val;
      end
    end
  end

  // Bus strobes, address and write data decoded from the latched M-cycle type.
  always_comb begin
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_mem_addr = r_pc;
    o_mem_dout = 8'h00;
    unique case (r_op)
      BUS_FETCH: begin
        o_mem_rd = (w_t_state != T4);
      end
      BUS_READ: begin
        o_mem_rd   = (w_t_state != T4);
        o_mem_addr = r_addr;
      end
      BUS_WRITE: begin
        o_mem_addr = r_addr;
        o_mem_dout = r_wdata;
        o_mem_wr   = !w_t1 && !w_t4;
      end
      default: begin
        o_mem_rd = 1'b0;
      end
    endcase
  end

  assign o_pc          = r_pc;
  assign o_ir          = r_ir;
  assign o_rdata       = r_rdata;
  assign o_mcycle_done = w_t4;
  assign o_ir_valid    = w_t4 && (r_op == BUS_FETCH) && w_opcode_done;

endmodule

// File: tb/tb_sm83_fetch.sv
// Self-checking bench for sm83_fetch: directed test-plan steps plus random M-cycles
// checked every T-state against a per-M-cycle behavioural model.
module tb_sm83_fetch;
  import sm83_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  bus_op;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] pc;
  logic [7:0]  ir;
  logic        ir_cb;
  logic [7:0]  rdata;
  logic        mcycle_done;
  logic        ir_valid;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [7:0]  m_ir;
  logic        m_ir_cb;
  logic [7:0]  m_rdata;
  logic        m_pending;
  logic        m_valid;

  sm83_fetch #(.RESET_PC(16'h0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_bus_op      (bus_op),
    .i_bus_addr    (bus_addr),
    .i_bus_wdata   (bus_wdata),
    .i_pc_load     (pc_load),
    .i_pc_load_val (pc_load_val),
    .o_pc          (pc),
    .o_ir          (ir),
    .o_ir_cb       (ir_cb),
    .o_rdata       (rdata),
    .o_mcycle_done (mcycle_done),
    .o_ir_valid    (ir_valid),
    .o_mem_addr    (mem_addr),
    .o_mem_rd      (mem_rd),
    .o_mem_wr      (mem_wr),
    .i_mem_din     (mem_din),
    .o_mem_dout    (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 16'h0000;
    m_ir      = 8'h00;
    m_ir_cb   = 1'b0;
    m_rdata   = 8'h00;
    m_pending = 1'b0;
    m_valid   = 1'b0;
  endtask

  // Called while in T4 of the previous M-cycle; returns in T4 (after negedge) of this one.
  task automatic mcycle(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] din, input logic ld, input logic [15:0] ldv);
    logic [1:0]  eff;
    logic        pre;
    logic [15:0] e_addr;
    bus_op = op;
    bus_addr = addr;
    bus_wdata = wd;
    @(posedge clk);
    #1;
    pre = m_pending;
    eff = pre ? 2'(BUS_FETCH) : op;
    mem_din = din;
    pc_load = 1'b0;
    m_valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
        // Mid-cycle request changes must be ignored
        bus_op = 2'($urandom);
        bus_addr = 16'($urandom);
        bus_wdata = 8'($urandom);
      end
      if (t == 3) begin
        pc_load = ld;
        pc_load_val = ldv;
        if (eff == BUS_FETCH) begin
          m_ir = din;
          m_pc = m_pc + 16'd1;
`ifdef SM83_CB_PREFIX_EN
          m_ir_cb   = pre;
          m_pending = !pre && (din == CB_PREFIX);
          m_valid   = !m_pending;
`else
          m_valid   = 1'b1;
`endif
        end else if (eff == BUS_READ) begin
          m_rdata = din;
        end
      end
      @(negedge clk);
      e_addr = (eff == BUS_READ || eff == BUS_WRITE) ? addr : m_pc;
      chk("mem_rd", 32'(mem_rd), 32'((eff == BUS_FETCH || eff == BUS_READ) && t < 3));
      chk("mem_wr", 32'(mem_wr), 32'(eff == BUS_WRITE && (t == 1 || t == 2)));
      chk("rd_wr_excl", 32'(mem_rd && mem_wr), 32'd0);
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_dout", 32'(mem_dout), 32'(eff == BUS_WRITE ? wd : 8'h00));
      chk("mcycle_done", 32'(mcycle_done), 32'(t == 3));
      chk("ir_valid", 32'(ir_valid), 32'(t == 3 && m_valid));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("ir_cb", 32'(ir_cb), 32'(m_ir_cb));
      chk("rdata", 32'(rdata), 32'(m_rdata));
    end
    if (ld && !pre) m_pc = ldv;
  endtask

  initial begin
    logic [1:0] rop;
    logic [7:0] rdin;
    logic [15:0] pc_before;
    rst_n = 1'b0;
    bus_op = 2'(BUS_IDLE);
    bus_addr = 16'h0000;
    bus_wdata = 8'h00;
    pc_load = 1'b0;
    pc_load_val = 16'h0000;
    mem_din = 8'h00;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h0000);
    chk("rst_ir", 32'(ir), 32'h00);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_done", 32'(mcycle_done), 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_dout", 32'(mem_dout), 32'h00);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_ir_cb", 32'(ir_cb), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Now in T1 of the idle M-cycle following release
    for (int t = 0; t < 4; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk("post_rst_done", 32'(mcycle_done), 32'(t == 3));
    end

    // Fetch 3E at pc 0
    mcycle(2'(BUS_FETCH), 16'h1234, 8'h00, 8'h3E, 1'b0, 16'h0000);
    chk("fetch_ir", 32'(ir), 32'h3E);
    chk("fetch_pc", 32'(pc), 32'h0001);

    // Write 5A to C000
    mcycle(2'(BUS_WRITE), 16'hC000, 8'h5A, 8'h77, 1'b0, 16'h0000);

    // PC wrap FFFF -> 0000
    mcycle(2'(BUS_IDLE), 16'h0000, 8'h00, 8'h00, 1'b1, 16'hFFFF);
    mcycle(2'(BUS_FETCH), 16'h0000, 8'h00, 8'h21, 1'b0, 16'h0000);
    chk("wrap_pc", 32'(pc), 32'h0000);

    // Same fetch at FFFF with pc_load overriding the increment
    mcycle(2'(BUS_IDLE), 16'h0000, 8'h00, 8'h00, 1'b1, 16'hFFFF);
    mcycle(2'(BUS_FETCH), 16'h0000, 8'h00, 8'h21, 1'b1, 16'h0150);
    mcycle(2'(BUS_IDLE), 16'h0000, 8'h00, 8'h00, 1'b0, 16'h0000);
    chk("load_pc", 32'(pc), 32'h0150);

    // CB prefix followed by 7C, second request is IDLE
    pc_before = m_pc;
    mcycle(2'(BUS_FETCH), 16'h0000, 8'h00, 8'hCB, 1'b0, 16'h0000);
    mcycle(2'(BUS_IDLE), 16'h0000, 8'h00, 8'h7C, 1'b0, 16'h0000);
`ifdef SM83_CB_PREFIX_EN
    chk("cb_ir", 32'(ir), 32'h7C);
    chk("cb_ir_cb", 32'(ir_cb), 32'd1);
    chk("cb_pc", 32'(pc), 32'(pc_before + 16'd2));
`else
    chk("cb_ir", 32'(ir), 32'hCB);
    chk("cb_ir_cb", 32'(ir_cb), 32'd0);
    chk("cb_pc", 32'(pc), 32'(pc_before + 16'd1));
`endif
    mcycle(2'(BUS_FETCH), 16'h0000, 8'h00, 8'h00, 1'b0, 16'h0000);

    // Random M-cycles
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      rdin = ($urandom_range(0, 5) == 0) ? 8'hCB : 8'($urandom);
      mcycle(rop, 16'($urandom), 8'($urandom), rdin, ($urandom_range(0, 7) == 0),
             16'($urandom));
    end
    // Drain any pending prefix so the reset test starts from a plain cycle
    mcycle(2'(BUS_IDLE), 16'h0000, 8'h00, 8'h00, 1'b0, 16'h0000);
    mcycle(2'(BUS_IDLE), 16'h0000, 8'h00, 8'h00, 1'b0, 16'h0000);
    pc_load = 1'b0;

    // Reset asserted during T2 of a read
    bus_op = 2'(BUS_READ);
    bus_addr = 16'h8800;
    @(posedge clk);
    #1 mem_din = 8'h99;
    @(posedge clk);
    @(negedge clk);
    chk("rd_t2_mem_rd", 32'(mem_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'h0000);
    chk("mid_rst_addr", 32'(mem_addr), 32'h0000);
    chk("mid_rst_rdata", 32'(rdata), 32'h00);
    chk("mid_rst_ir", 32'(ir), 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("held_rst_rdata", 32'(rdata), 32'h00);
    chk("held_rst_done", 32'(mcycle_done), 32'd0);
    bus_op = 2'(BUS_IDLE);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int t = 0; t < 4; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      chk("restart_done", 32'(mcycle_done), 32'(t == 3));
      chk("restart_rd", 32'(mem_rd), 32'd0);
    end
    mcycle(2'(BUS_FETCH), 16'h0000, 8'h00, 8'h3C, 1'b0, 16'h0000);
    chk("restart_fetch_pc", 32'(pc), 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
